// File: rtl/relu_maxpool_2x2.sv
// relu_maxpool_2x2: ReLU + 2x2 stride-2 max pooling over a raster-ordered conv result stream.
// Optional feature macro: MAXPOOL_RELU_EN (defined = ReLU applied, undefined = raw signed pooling).
module relu_maxpool_2x2 #(
  parameter int DATA_W = 21,
  parameter int IN_W   = 22,
  parameter int IN_H   = 22
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     data_valid_in,
  input  logic signed [DATA_W-1:0] pixel_in,
  input  logic [4:0]               hcount_in,
  input  logic [4:0]               vcount_in,
  output logic                     data_valid_out,
  output logic signed [DATA_W-1:0] pixel_out,
  output logic [3:0]               hcount_out,
  output logic [3:0]               vcount_out,
  output logic                     frame_done_out,
  output logic                     seq_err_out
);
  localparam int PW = IN_W / 2;
  localparam int AW = PW > 1 ? $clog2(PW) : 1;
  localparam logic [4:0] LAST_H = 5'(IN_W - 1);
  localparam logic [4:0] LAST_V = 5'(IN_H - 1);
  localparam logic [3:0] POOL_H = 4'(IN_W / 2 - 1);
  localparam logic [3:0] POOL_V = 4'(IN_H / 2 - 1);
  typedef enum logic {WAIT_SOF, ACTIVE} state_t;
  state_t state;
  logic [4:0] exp_h, exp_v;
  logic signed [DATA_W-1:0] r, pm, pair_reg, s1_pm, s1_buf;
  logic signed [DATA_W-1:0] row_buf [PW];
  logic [AW-1:0] idx;
  logic [3:0] s1_h, s1_v;
  logic s1_valid, s1_last, accept, row_end, frame_end;
  assign idx = AW'(hcount_in[4:1]);
`ifdef MAXPOOL_RELU_EN
  assign r = pixel_in[DATA_W-1] ? '0 : pixel_in;
`else
  assign r = pixel_in;
`endif
  assign pm = (pair_reg > r) ? pair_reg : r;
  assign accept = data_valid_in && (state == WAIT_SOF ? (hcount_in == '0 && vcount_in == '0)
                                                      : (hcount_in == exp_h && vcount_in == exp_v));
  assign row_end = hcount_in == LAST_H;
  assign frame_end = row_end && vcount_in == LAST_V;
  // Raster-order checker: tracks the expected coordinate and drops out-of-order samples.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= WAIT_SOF;
      exp_h <= '0;
      exp_v <= '0;
      seq_err_out <= 1'b0;
    end else if (accept) begin
      state <= frame_end ? WAIT_SOF : ACTIVE;
      exp_h <= row_end ? '0 : hcount_in + 5'd1;
      exp_v <= frame_end ? '0 : row_end ? vcount_in + 5'd1 : vcount_in;
    end else if (data_valid_in && state == ACTIVE) begin
      state <= WAIT_SOF;
      exp_h <= '0;
      exp_v <= '0;
      seq_err_out <= 1'b1;
    end
  end
  // Stage 1: horizontal pair max, and on odd rows hand the pair max plus the buffered upper pair to stage 2.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pair_reg <= '0;
      s1_valid <= 1'b0;
      s1_pm <= '0;
      s1_buf <= '0;
      s1_h <= '0;
      s1_v <= '0;
      s1_last <= 1'b0;
    end else begin
      if (accept && !hcount_in[0]) pair_reg <= r;
      s1_valid <= accept && hcount_in[0] && vcount_in[0];
      if (accept && hcount_in[0] && vcount_in[0]) begin
        s1_pm <= pm;
        s1_buf <= row_buf[idx];
        s1_h <= hcount_in[4:1];
        s1_v <= vcount_in[4:1];
        s1_last <= hcount_in[4:1] == POOL_H && vcount_in[4:1] == POOL_V;
      end
    end
  end
  // Row buffer holds even-row pair maxima; contents survive reset since every frame rewrites them before use.
  always_ff @(posedge clk_in) begin
    if (accept && hcount_in[0] && !vcount_in[0]) row_buf[idx] <= pm;
  end
  // Stage 2: vertical max and registered outputs; data holds while valid is low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_valid_out <= 1'b0;
      frame_done_out <= 1'b0;
      pixel_out <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
    end else begin
      data_valid_out <= s1_valid;
      frame_done_out <= s1_valid && s1_last;
      if (s1_valid) begin
        pixel_out <= (s1_pm > s1_buf) ? s1_pm : s1_buf;
        hcount_out <= s1_h;
        vcount_out <= s1_v;
      end
    end
  end
endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// tb_relu_maxpool_2x2: directed checks of ReLU/max-pool on a 22x22 and a 5x5 instance.
module tb_relu_maxpool_2x2;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;
  logic a_dv = 1'b0, b_dv = 1'b0;
  logic signed [20:0] a_px = '0, b_px = '0;
  logic [4:0] a_h = '0, a_v = '0, b_h = '0, b_v = '0;
  logic a_dvo, a_fd, a_err, b_dvo, b_fd, b_err;
  logic signed [20:0] a_pix, b_pix;
  logic [3:0] a_ho, a_vo, b_ho, b_vo;
  int checks = 0;
  int errors = 0;
  int fd_a = 0;
  typedef struct packed {
    logic fd;
    logic [3:0] h;
    logic [3:0] v;
    logic [20:0] p;
  } out_t;
  out_t qa[$];
  out_t qb[$];
  logic signed [20:0] img [22][22];

  relu_maxpool_2x2 u_a (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .data_valid_in(a_dv), .pixel_in(a_px),
    .hcount_in(a_h), .vcount_in(a_v), .data_valid_out(a_dvo), .pixel_out(a_pix),
    .hcount_out(a_ho), .vcount_out(a_vo), .frame_done_out(a_fd), .seq_err_out(a_err));
  relu_maxpool_2x2 #(.IN_W(5), .IN_H(5)) u_b (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .data_valid_in(b_dv), .pixel_in(b_px),
    .hcount_in(b_h), .vcount_in(b_v), .data_valid_out(b_dvo), .pixel_out(b_pix),
    .hcount_out(b_ho), .vcount_out(b_vo), .frame_done_out(b_fd), .seq_err_out(b_err));

  always @(negedge clk_in) begin
    if (a_dvo) qa.push_back({a_fd, a_ho, a_vo, a_pix});
    if (b_dvo) qb.push_back({b_fd, b_ho, b_vo, b_pix});
    if (a_fd) fd_a++;
  end

  function automatic logic signed [20:0] act(input logic signed [20:0] x);
`ifdef MAXPOOL_RELU_EN
    return (x < 0) ? 21'sd0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic signed [20:0] pool_exp(input int j, input int i);
    logic signed [20:0] m, c;
    m = act(img[2*j][2*i]);
    c = act(img[2*j][2*i+1]);   if (c > m) m = c;
    c = act(img[2*j+1][2*i]);   if (c > m) m = c;
    c = act(img[2*j+1][2*i+1]); if (c > m) m = c;
    return m;
  endfunction

  task automatic drive_a(input logic dv, input int h, input int v, input int p);
    @(negedge clk_in);
    a_dv = dv; a_h = 5'(h); a_v = 5'(v); a_px = 21'(p);
  endtask

  task automatic idle_a();
    drive_a(1'b0, 0, 0, 0);
  endtask

  task automatic drive_b(input logic dv, input int h, input int v, input int p);
    @(negedge clk_in);
    b_dv = dv; b_h = 5'(h); b_v = 5'(v); b_px = 21'(p);
  endtask

  task automatic clear_q();
    @(posedge clk_in);
    qa.delete(); qb.delete(); fd_a = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    a_dv = 1'b0; b_dv = 1'b0;
    #2 rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  task automatic fill_img();
    for (int v = 0; v < 22; v++)
      for (int h = 0; h < 22; h++) begin
        int x;
        x = int'($urandom_range(0, 4000)) - 2000;
        img[v][h] = 21'(x);
      end
    img[0][0] = -21'sd1048576;
    img[0][1] = 21'sd1048575;
  endtask

  task automatic send_frame_a(input bit bubbles);
    for (int v = 0; v < 22; v++)
      for (int h = 0; h < 22; h++) begin
        if (bubbles) repeat ($urandom_range(0, 2)) idle_a();
        drive_a(1'b1, h, v, int'(img[v][h]));
      end
    repeat (5) idle_a();
  endtask

  task automatic send_window_a(input int a0, input int a1, input int b0, input int b1);
    for (int h = 0; h < 22; h++) drive_a(1'b1, h, 0, h == 0 ? a0 : h == 1 ? a1 : 0);
    drive_a(1'b1, 0, 1, b0);
    drive_a(1'b1, 1, 1, b1);
  endtask

  task automatic test_window_max();
    do_reset();
    send_window_a(5, -3, 9, 2);
    idle_a();
    checks++;
    if (a_dvo !== 1'b0) begin errors++; $display("FAIL window_early_valid: got %0b expected 0", a_dvo); end
    idle_a();
    checks++;
    if (a_dvo !== 1'b1 || a_pix !== 21'sd9 || a_ho !== 4'd0 || a_vo !== 4'd0) begin
      errors++;
      $display("FAIL window_max: got v=%0b p=%0d h=%0d v=%0d expected v=1 p=9 h=0 v=0", a_dvo, a_pix, a_ho, a_vo);
    end
    idle_a();
    checks++;
    if (a_dvo !== 1'b0 || a_pix !== 21'sd9) begin errors++; $display("FAIL window_hold: got v=%0b p=%0d expected v=0 p=9", a_dvo, a_pix); end
  endtask

  task automatic test_negative();
    logic signed [20:0] e;
`ifdef MAXPOOL_RELU_EN
    e = 21'sd0;
`else
    e = -21'sd1;
`endif
    do_reset();
    send_window_a(-7, -1, -4, -2);
    idle_a();
    idle_a();
    checks++;
    if (a_dvo !== 1'b1 || a_pix !== e) begin
      errors++;
      $display("FAIL negative_window: got v=%0b p=%0d expected v=1 p=%0d", a_dvo, a_pix, e);
    end
  endtask

  task automatic test_seq_error();
    do_reset();
    drive_a(1'b1, 0, 0, 1);
    drive_a(1'b1, 1, 0, 2);
    drive_a(1'b1, 3, 0, 3);
    checks++;
    if (a_err !== 1'b0) begin errors++; $display("FAIL seq_err_early: got %0b expected 0", a_err); end
    idle_a();
    checks++;
    if (a_err !== 1'b1) begin errors++; $display("FAIL seq_err_rise: got %0b expected 1", a_err); end
    drive_a(1'b1, 5, 5, 77);
    drive_a(1'b1, 2, 0, 77);
    fill_img();
    clear_q();
    send_frame_a(1'b0);
    checks++;
    if (qa.size() != 121) begin errors++; $display("FAIL seq_recover_count: got %0d expected 121", qa.size()); end
    for (int k = 0; k < 121 && k < qa.size(); k++) begin
      checks++;
      if (qa[k].p !== pool_exp(k / 11, k % 11) || qa[k].h !== 4'(k % 11) || qa[k].v !== 4'(k / 11)) begin
        errors++;
        $display("FAIL seq_recover[%0d]: got p=%0d h=%0d v=%0d expected p=%0d h=%0d v=%0d",
                 k, $signed(qa[k].p), qa[k].h, qa[k].v, pool_exp(k / 11, k % 11), k % 11, k / 11);
      end
    end
    checks++;
    if (a_err !== 1'b1) begin errors++; $display("FAIL seq_err_sticky: got %0b expected 1", a_err); end
  endtask

  task automatic test_reset();
    send_window_a(1, 2, 3, 4);
    #2 rst_n_in = 1'b0;
    a_dv = 1'b0;
    #1;
    checks++;
    if ({a_dvo, a_fd, a_err, a_ho, a_vo} !== 11'd0 || a_pix !== 21'sd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b fd=%0b err=%0b h=%0d v=%0d p=%0d expected all 0", a_dvo, a_fd, a_err, a_ho, a_vo, a_pix);
    end
    checks++;
    if (b_err !== 1'b0 || b_dvo !== 1'b0) begin errors++; $display("FAIL reset_b: got err=%0b v=%0b expected 0 0", b_err, b_dvo); end
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    clear_q();
    fill_img();
    send_frame_a(1'b0);
    checks++;
    if (qa.size() != 121) begin errors++; $display("FAIL reset_frame_count: got %0d expected 121", qa.size()); end
    checks++;
    if (fd_a != 1) begin errors++; $display("FAIL reset_frame_done: got %0d expected 1", fd_a); end
    for (int k = 0; k < 121 && k < qa.size(); k++) begin
      checks++;
      if (qa[k].p !== pool_exp(k / 11, k % 11) || qa[k].h !== 4'(k % 11) || qa[k].v !== 4'(k / 11) || qa[k].fd !== (k == 120)) begin
        errors++;
        $display("FAIL reset_frame[%0d]: got p=%0d h=%0d v=%0d fd=%0b expected p=%0d h=%0d v=%0d fd=%0b",
                 k, $signed(qa[k].p), qa[k].h, qa[k].v, qa[k].fd, pool_exp(k / 11, k % 11), k % 11, k / 11, k == 120);
      end
    end
  endtask

  task automatic test_bubbles();
    do_reset();
    fill_img();
    clear_q();
    send_frame_a(1'b1);
    checks++;
    if (qa.size() != 121 || fd_a != 1) begin
      errors++;
      $display("FAIL bubbles_count: got n=%0d fd=%0d expected n=121 fd=1", qa.size(), fd_a);
    end
    for (int k = 0; k < 121 && k < qa.size(); k++) begin
      checks++;
      if (qa[k].p !== pool_exp(k / 11, k % 11) || qa[k].h !== 4'(k % 11) || qa[k].v !== 4'(k / 11) || qa[k].fd !== (k == 120)) begin
        errors++;
        $display("FAIL bubbles[%0d]: got p=%0d h=%0d v=%0d fd=%0b expected p=%0d h=%0d v=%0d fd=%0b",
                 k, $signed(qa[k].p), qa[k].h, qa[k].v, qa[k].fd, pool_exp(k / 11, k % 11), k % 11, k / 11, k == 120);
      end
    end
    checks++;
    if (a_err !== 1'b0) begin errors++; $display("FAIL bubbles_seq_err: got %0b expected 0", a_err); end
  endtask

  task automatic test_odd_size();
    int ev[4] = '{11, 13, 31, 33};
    int eh[4] = '{0, 1, 0, 1};
    int evv[4] = '{0, 0, 1, 1};
    do_reset();
    clear_q();
    for (int f = 0; f < 2; f++)
      for (int v = 0; v < 5; v++)
        for (int h = 0; h < 5; h++) drive_b(1'b1, h, v, 10 * v + h);
    repeat (5) drive_b(1'b0, 0, 0, 0);
    checks++;
    if (qb.size() != 8) begin errors++; $display("FAIL odd_count: got %0d expected 8", qb.size()); end
    for (int k = 0; k < 8 && k < qb.size(); k++) begin
      checks++;
      if (qb[k].p !== 21'(ev[k % 4]) || qb[k].h !== 4'(eh[k % 4]) || qb[k].v !== 4'(evv[k % 4]) || qb[k].fd !== (k % 4 == 3)) begin
        errors++;
        $display("FAIL odd[%0d]: got p=%0d h=%0d v=%0d fd=%0b expected p=%0d h=%0d v=%0d fd=%0b",
                 k, $signed(qb[k].p), qb[k].h, qb[k].v, qb[k].fd, ev[k % 4], eh[k % 4], evv[k % 4], k % 4 == 3);
      end
    end
    checks++;
    if (b_err !== 1'b0) begin errors++; $display("FAIL odd_seq_err: got %0b expected 0", b_err); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    test_window_max();
    test_negative();
    test_seq_error();
    test_reset();
    test_bubbles();
    test_odd_size();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
